pc_sequencer: RTL



---
 rtl/pc_sequencer.sv | 113 +++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter owner and BOOT/FETCH/EXEC fetch sequencer.
// Optional macro PC_SEQ_MISALIGN_TRAP_EN: misaligned redirect targets trap to EXC_VECTOR.
`default_nettype none

module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        exc,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  output logic [31:0] epc
`ifdef PC_SEQ_MISALIGN_TRAP_EN
  ,
  output logic        misalign_trap
`endif
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc_next, epc_next;
  logic [31:0] jump_dest, branch_dest;
  logic        redirect_trap;

`ifdef PC_SEQ_MISALIGN_TRAP_EN
  logic trap_next;

  assign jump_dest     = jump_target;
  assign branch_dest   = branch_target;
  // Only the redirect that would actually win priority can raise the trap.
  assign redirect_trap = jump ? (jump_target[1:0] != 2'b00)
                              : (branch_taken && (branch_target[1:0] != 2'b00));
`else
  assign jump_dest     = jump_target & ~32'h3;
  assign branch_dest   = branch_target & ~32'h3;
  assign redirect_trap = 1'b0;
`endif

  assign imem_req    = (state == FETCH);
  assign instr_valid = (state == EXEC);
  assign imem_addr   = pc;
  assign pc_plus4    = pc + 32'd4;

  always_comb begin
    state_next = state;
    pc_next    = pc;
    epc_next   = epc;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    trap_next  = 1'b0;
`endif
    case (state)
      BOOT:  state_next = FETCH;
      FETCH: if (imem_ack) state_next = EXEC;
      EXEC: begin
        if (!stall) begin
          state_next = FETCH;
          if (exc || redirect_trap) begin
            epc_next = pc;
            pc_next  = EXC_VECTOR;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
            trap_next = !exc;
`endif
          end else if (jump) begin
            pc_next = jump_dest;
          end else if (branch_taken) begin
            pc_next = branch_dest;
          end else begin
            pc_next = pc_plus4;
          end
        end
      end
      default: state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= BOOT;
      pc    <= RESET_VECTOR;
      epc   <= 32'h0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      epc   <= epc_next;
    end
  end

`ifdef PC_SEQ_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) misalign_trap <= 1'b0;
    else      misalign_trap <= trap_next;
  end
`endif

endmodule

`default_nettype wire
